// File: rtl/chirp_frame_sequencer_pkg.sv
// rtl/chirp_frame_sequencer_pkg.sv - shared encodings and defaults for the chirp frame sequencer
package chirp_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam logic [7:0] SYNC_SYM_0_DEF = 8'h08;
  localparam logic [7:0] SYNC_SYM_1_DEF = 8'h10;

  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PRE  = 3'd2;
  localparam logic [2:0] ST_SYNC = 3'd3;
  localparam logic [2:0] ST_PAY  = 3'd4;

  typedef enum logic [2:0] {
    S_HDR  = ST_HDR,
    S_LOAD = ST_LOAD,
    S_PRE  = ST_PRE,
    S_SYNC = ST_SYNC,
    S_PAY  = ST_PAY
  } state_t;

endpackage

// File: rtl/chirp_frame_sequencer_if.sv
// rtl/chirp_frame_sequencer_if.sv - receiver and modulator strobe bundle of the frame sequencer
interface chirp_frame_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  i_rx_valid_n;
  logic                  i_chirp_done_n;
  logic                  o_start_n;
  logic [DATA_WIDTH-1:0] o_symbol;
  logic                  o_busy;
  logic                  o_frame_done_n;
  logic                  o_err;

  modport slave (
    input  i_rx_data, i_rx_valid_n, i_chirp_done_n,
    output o_start_n, o_symbol, o_busy, o_frame_done_n, o_err
  );

  modport master (
    output i_rx_data, i_rx_valid_n, i_chirp_done_n,
    input  o_start_n, o_symbol, o_busy, o_frame_done_n, o_err
  );
endinterface

// File: rtl/chirp_frame_sequencer_sym_fifo.sv
// rtl/chirp_frame_sequencer_sym_fifo.sv - synchronous show-ahead payload symbol buffer
module sym_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/chirp_frame_sequencer.sv
// rtl/chirp_frame_sequencer.sv - buffers a length-prefixed frame then paces preamble, sync and payload chirps
module chirp_frame_sequencer
  import chirp_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int                    FIFO_DEPTH   = 16,
  parameter int                    PREAMBLE_LEN = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_SYM_0   = SYNC_SYM_0_DEF,
  parameter logic [DATA_WIDTH-1:0] SYNC_SYM_1   = SYNC_SYM_1_DEF
) (
  input logic                    i_clk,
  input logic                    i_rst,
  chirp_frame_sequencer_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            pre_q, pre_d;
  logic                  sync_q, sync_d;
  logic                  pend_q, pend_d;
  logic                  outst_q, outst_d;
  logic                  start_q, start_d;
  logic [DATA_WIDTH-1:0] sym_q, sym_d;
  logic                  busy_q, busy_d;
  logic                  fdone_q, fdone_d;
  logic                  err_q, err_d;
  logic                  wr_en, rd_en, full, empty;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rx, done;

  assign rx   = !bus.i_rx_valid_n;
  assign done = !bus.i_chirp_done_n;

  sym_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk(i_clk), .rst(i_rst), .wr_en(wr_en), .rd_en(rd_en),
    .din(bus.i_rx_data), .dout(dout), .full(full), .empty(empty)
  );

  always_comb begin
    state_d = state_q; len_d = len_q; cnt_d = cnt_q; pre_d = pre_q;
    sync_d = sync_q; pend_d = pend_q; outst_d = outst_q; start_d = 1'b1;
    sym_d = sym_q; busy_d = busy_q; fdone_d = 1'b1; err_d = err_q;
    wr_en = 1'b0; rd_en = 1'b0;
    if (done && !outst_q) err_d = 1'b1;
    case (state_q)
      S_HDR: if (rx) begin
        if (bus.i_rx_data == '0 || 32'(bus.i_rx_data) > FIFO_DEPTH) begin
          err_d = 1'b1;
        end else begin
          len_d   = CW'(bus.i_rx_data);
          cnt_d   = CW'(bus.i_rx_data);
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: if (rx) begin
        wr_en = !full;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_PRE;
          pend_d  = 1'b1;
          pre_d   = '0;
        end
      end
      S_PRE: begin
        if (rx) err_d = 1'b1;
        // First preamble chirp goes out one cycle after the last byte lands.
        if (pend_q) begin
          pend_d = 1'b0; outst_d = 1'b1; start_d = 1'b0; sym_d = '0; pre_d = 8'd1;
        end else if (done && outst_q) begin
          start_d = 1'b0;
          if (pre_q == 8'(PREAMBLE_LEN)) begin
            state_d = S_SYNC; sym_d = SYNC_SYM_0; sync_d = 1'b0;
          end else begin
            sym_d = '0; pre_d = pre_q + 8'd1;
          end
        end
      end
      S_SYNC: begin
        if (rx) err_d = 1'b1;
        if (done && outst_q) begin
          start_d = 1'b0;
          if (!sync_q) begin
            sym_d = SYNC_SYM_1; sync_d = 1'b1;
          end else begin
            state_d = S_PAY; sym_d = dout; rd_en = 1'b1; cnt_d = len_q - CW'(1);
          end
        end
      end
      S_PAY: begin
        if (rx) err_d = 1'b1;
        if (done && outst_q) begin
          if (cnt_q != '0) begin
            start_d = 1'b0; sym_d = dout; rd_en = 1'b1; cnt_d = cnt_q - CW'(1);
          end else begin
            fdone_d = 1'b0; busy_d = 1'b0; outst_d = 1'b0; state_d = S_HDR;
          end
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_HDR; len_q <= '0; cnt_q <= '0; pre_q <= '0; sync_q <= 1'b0;
      pend_q <= 1'b0; outst_q <= 1'b0; start_q <= 1'b1; sym_q <= '0;
      busy_q <= 1'b0; fdone_q <= 1'b1; err_q <= 1'b0;
    end else begin
      state_q <= state_d; len_q <= len_d; cnt_q <= cnt_d; pre_q <= pre_d; sync_q <= sync_d;
      pend_q <= pend_d; outst_q <= outst_d; start_q <= start_d; sym_q <= sym_d;
      busy_q <= busy_d; fdone_q <= fdone_d; err_q <= err_d;
    end
  end

  assign bus.o_start_n      = start_q;
  assign bus.o_symbol       = sym_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_frame_done_n = fdone_q;
  assign bus.o_err          = err_q;
endmodule
